// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: requester-side and register-file-side signals of the shared RF port arbiter.
interface regfile_port_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = 2
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    u_read_en;
    logic [4*N_REQ-1:0]  u_read_reg;
    logic [N_REQ-1:0]    u_write_en;
    logic [4*N_REQ-1:0]  u_write_reg;
    logic [32*N_REQ-1:0] u_write_value;
    logic [31:0]         u_read_value;
    logic                rf_read_en;
    logic [3:0]          rf_read_reg;
    logic                rf_write_en;
    logic [3:0]          rf_write_reg;
    logic [31:0]         rf_write_value;
    logic [31:0]         rf_read_value;
    logic                owner_valid;
    logic [OWNER_W-1:0]  owner_id;
    logic                err_starve;

    modport master (
        output req, u_read_en, u_read_reg, u_write_en, u_write_reg, u_write_value, rf_read_value,
        input  gnt, u_read_value, rf_read_en, rf_read_reg, rf_write_en, rf_write_reg, rf_write_value,
               owner_valid, owner_id, err_starve
    );
    modport slave (
        input  req, u_read_en, u_read_reg, u_write_en, u_write_reg, u_write_value, rf_read_value,
        output gnt, u_read_value, rf_read_en, rf_read_reg, rf_write_en, rf_write_reg, rf_write_value,
               owner_valid, owner_id, err_starve
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin ownership of the single RF read and write port pair,
// held for as long as the owner keeps its request high.
module regfile_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int OWNER_W  = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [OWNER_W-1:0] r_owner_id;
    logic [OWNER_W-1:0] r_rr_ptr;
    logic [7:0]         r_hold_cnt;
    logic               r_err_starve;

    logic [OWNER_W-1:0] w_ptr;
    logic [OWNER_W-1:0] w_pick;
    logic               w_found;
    logic               w_owner_req;
    logic               w_starve;
    logic [7:0]         w_hold_inc;
    logic               w_valid;

    // On release the scan starts just past the old owner, so it goes to the back of the line.
    always_comb begin
        w_owner_req = bus.req[r_owner_id];
        w_ptr       = (r_state == OWN) ? OWNER_W'((int'(r_owner_id) + 1) % N_REQ) : r_rr_ptr;
        w_found     = 1'b0;
        w_pick      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(w_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_pick  = OWNER_W'((int'(w_ptr) + k) % N_REQ);
            end
        end
        w_hold_inc = (r_hold_cnt == 8'hff) ? r_hold_cnt : r_hold_cnt + 8'd1;
        w_starve   = (r_state == OWN) && w_owner_req && (w_hold_inc >= 8'(MAX_HOLD))
                     && |(bus.req & ~r_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_owner_id   <= '0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
            r_err_starve <= 1'b0;
        end else begin
            if (w_starve)
                r_err_starve <= 1'b1;
            if (r_state == IDLE || !w_owner_req) begin
                if (r_state == OWN)
                    r_rr_ptr <= w_ptr;
                r_state    <= w_found ? OWN : IDLE;
                r_owner_id <= w_found ? w_pick : '0;
                r_gnt      <= w_found ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_pick) : '0;
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= w_hold_inc;
            end
        end
    end

    assign w_valid            = (r_state == OWN);
    assign bus.gnt            = r_gnt;
    assign bus.owner_valid    = w_valid;
    assign bus.owner_id       = r_owner_id;
    assign bus.err_starve     = r_err_starve;
    assign bus.u_read_value   = bus.rf_read_value;
    assign bus.rf_read_en     = w_valid & bus.u_read_en[r_owner_id];
    assign bus.rf_write_en    = w_valid & bus.u_write_en[r_owner_id];
    assign bus.rf_read_reg    = w_valid ? bus.u_read_reg[{r_owner_id, 2'b00} +: 4] : '0;
    assign bus.rf_write_reg   = w_valid ? bus.u_write_reg[{r_owner_id, 2'b00} +: 4] : '0;
    assign bus.rf_write_value = w_valid ? bus.u_write_value[{r_owner_id, 5'b00000} +: 32] : '0;
endmodule
